// File: rtl/arbitro_compuerta.sv
// Two-lane round-robin gate arbiter: grants one lane, checks its PIN, sequences
// open/close, and locks out on repeated bad PINs, intrusion or tailgating.
module arbitro_compuerta #(
  parameter logic [15:0] CLAVE_CORRECTA = 16'h2468,
  parameter int unsigned MAX_INTENTOS   = 3,
  parameter int unsigned TIMEOUT_CICLOS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  LV,
  input  logic [1:0]  PV,
  input  logic [15:0] clave0,
  input  logic [15:0] clave1,
  input  logic [1:0]  CV,
  input  logic        BR,
  output logic [1:0]  GNT,
  output logic        AC,
  output logic        CP,
  output logic        AI,
  output logic        AB
);

  localparam int unsigned TW = $clog2(TIMEOUT_CICLOS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PIN  = 2'd1;
  localparam logic [1:0] OPEN = 2'd2;
  localparam logic [1:0] BLOQ = 2'd3;

  logic [1:0]    estado, estado_nx;
  logic          g, g_nx;
  logic          ult, ult_nx;
  logic [1:0]    intentos, intentos_nx, intentos_inc;
  logic [TW-1:0] timer, timer_nx;
  logic          ac_nx, cp_nx, ai_nx;
  logic [15:0]   clave_g;
  logic          expira;

  assign clave_g      = g ? clave1 : clave0;
  assign intentos_inc = intentos + 2'd1;
  assign expira       = (timer == TW'(TIMEOUT_CICLOS));

  always_comb begin
    estado_nx   = estado;
    g_nx        = g;
    ult_nx      = ult;
    intentos_nx = intentos;
    timer_nx    = timer;
    ac_nx       = 1'b0;
    cp_nx       = 1'b0;
    ai_nx       = 1'b0;
    case (estado)
      IDLE: begin
        intentos_nx = '0;
        timer_nx    = '0;
        if (LV != 2'b00) begin
          estado_nx = PIN;
          // single requester wins outright; a tie goes to the lane not served last
          g_nx = (LV == 2'b11) ? ~ult : LV[1];
        end
      end
      PIN: begin
        if (CV != 2'b00) begin
          estado_nx = BLOQ;
        end else if (PV[g]) begin
          timer_nx = '0;
          if (clave_g == CLAVE_CORRECTA) begin
            ac_nx     = 1'b1;
            estado_nx = OPEN;
            ult_nx    = g;
          end else begin
            ai_nx       = 1'b1;
            intentos_nx = intentos_inc;
            if (intentos_inc == 2'(MAX_INTENTOS))
              estado_nx = BLOQ;
          end
        end else if (!LV[g] || expira) begin
          estado_nx = IDLE;
          ult_nx    = g;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      OPEN: begin
        if (CV[~g] || (CV[g] && LV[g])) begin
          estado_nx = BLOQ;
        end else if (CV[g] || expira) begin
          cp_nx     = 1'b1;
          estado_nx = IDLE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: begin
        if (BR) begin
          estado_nx   = IDLE;
          intentos_nx = '0;
          timer_nx    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= IDLE;
      g        <= 1'b0;
      ult      <= 1'b1;
      intentos <= '0;
      timer    <= '0;
      GNT      <= '0;
      AC       <= 1'b0;
      CP       <= 1'b0;
      AI       <= 1'b0;
      AB       <= 1'b0;
    end else begin
      estado   <= estado_nx;
      g        <= g_nx;
      ult      <= ult_nx;
      intentos <= intentos_nx;
      timer    <= timer_nx;
      // grant and alarm derive from the next state so they move with it
      GNT      <= (estado_nx == PIN || estado_nx == OPEN) ? (g_nx ? 2'b10 : 2'b01) : 2'b00;
      AC       <= ac_nx;
      CP       <= cp_nx;
      AI       <= ai_nx;
      AB       <= (estado_nx == BLOQ);
    end
  end

endmodule

// File: tb/tb_arbitro_compuerta.sv
// Bench for arbitro_compuerta: directed vector table, timeout sequences, and
// randomized traffic checked against a behavioural model.
module tb_arbitro_compuerta;

  localparam logic [15:0] OK  = 16'h2468;
  localparam logic [15:0] BAD = 16'h1111;
  localparam int TO   = 8;
  localparam int MAXI = 3;

  logic        clk, reset, BR;
  logic [1:0]  LV, PV, CV, GNT;
  logic [15:0] clave0, clave1;
  logic        AC, CP, AI, AB;

  int checks = 0;
  int failures = 0;

  arbitro_compuerta #(.CLAVE_CORRECTA(16'h2468), .MAX_INTENTOS(3), .TIMEOUT_CICLOS(8)) dut (
    .clk(clk), .reset(reset), .LV(LV), .PV(PV), .clave0(clave0), .clave1(clave1),
    .CV(CV), .BR(BR), .GNT(GNT), .AC(AC), .CP(CP), .AI(AI), .AB(AB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [1:0]  lv, pv;
    logic [15:0] c0, c1;
    logic [1:0]  cv;
    logic        br;
    logic [5:0]  exp;  // {GNT, AC, CP, AI, AB}
  } vec_t;

  function automatic vec_t mk(logic rst, logic [1:0] lv, logic [1:0] pv, logic [15:0] c0,
                              logic [15:0] c1, logic [1:0] cv, logic br, logic [5:0] exp);
    vec_t v;
    v.rst = rst; v.lv = lv; v.pv = pv; v.c0 = c0; v.c1 = c1; v.cv = cv; v.br = br; v.exp = exp;
    return v;
  endfunction

  // Behavioural model: phase, owner lane, last served lane, bad tries, idle edges waited
  typedef enum {M_IDLE, M_PIN, M_OPEN, M_BLOQ} mph_t;
  mph_t m_ph;
  int   m_lane, m_last, m_tries, m_wait;
  logic m_ac, m_cp, m_ai;

  task automatic model_step();
    m_ac = 0; m_cp = 0; m_ai = 0;
    if (reset) begin
      m_ph = M_IDLE; m_last = 1; m_tries = 0; m_wait = 0; m_lane = 0;
    end else begin
      case (m_ph)
        M_IDLE: if (LV != 0) begin
          m_lane  = (LV == 2'b11) ? 1 - m_last : (LV == 2'b10 ? 1 : 0);
          m_ph    = M_PIN; m_tries = 0; m_wait = 0;
        end
        M_PIN: begin
          if (CV != 0) m_ph = M_BLOQ;
          else if (PV[m_lane]) begin
            m_wait = 0;
            if ((m_lane == 0 ? clave0 : clave1) == OK) begin
              m_ac = 1; m_ph = M_OPEN; m_last = m_lane;
            end else begin
              m_ai = 1; m_tries++;
              if (m_tries == MAXI) m_ph = M_BLOQ;
            end
          end else if (!LV[m_lane]) begin
            m_ph = M_IDLE; m_last = m_lane;
          end else begin
            m_wait++;
            if (m_wait > TO) begin m_ph = M_IDLE; m_last = m_lane; end
          end
        end
        M_OPEN: begin
          if (CV[1 - m_lane] || (CV[m_lane] && LV[m_lane])) m_ph = M_BLOQ;
          else if (CV[m_lane]) begin m_cp = 1; m_ph = M_IDLE; end
          else begin
            m_wait++;
            if (m_wait > TO) begin m_cp = 1; m_ph = M_IDLE; end
          end
        end
        default: if (BR) m_ph = M_IDLE;
      endcase
    end
  endtask

  function automatic logic [5:0] model_out();
    logic [1:0] gn;
    gn = (m_ph == M_PIN || m_ph == M_OPEN) ? (m_lane == 0 ? 2'b01 : 2'b10) : 2'b00;
    return {gn, m_ac, m_cp, m_ai, (m_ph == M_BLOQ)};
  endfunction

  task automatic step(logic r, logic [1:0] lv, logic [1:0] pv, logic [15:0] a,
                      logic [15:0] b, logic [1:0] cv, logic br);
    reset = r; LV = lv; PV = pv; clave0 = a; clave1 = b; CV = cv; BR = br;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(string name, logic [5:0] act, logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got={GNT,AC,CP,AI,AB}=%b want=%b", name, act, exp);
    end
  endtask

  vec_t vq[$];

  initial begin
    reset = 1; LV = 0; PV = 0; clave0 = 0; clave1 = 0; CV = 0; BR = 0;
    m_ph = M_IDLE; m_last = 1; m_tries = 0; m_wait = 0; m_lane = 0;
    m_ac = 0; m_cp = 0; m_ai = 0;

    // rst lv pv c0 c1 cv br  {GNT,AC,CP,AI,AB}
    // open/close cycle on lane 0
    vq.push_back(mk(1, 2'b00, 2'b00, 0,   0,  2'b00, 0, 6'b00_0000));
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b00, 0, 6'b01_0000));
    vq.push_back(mk(0, 2'b01, 2'b01, OK,  0,  2'b00, 0, 6'b01_1000));
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b00, 0, 6'b01_0000));
    vq.push_back(mk(0, 2'b00, 2'b00, 0,   0,  2'b01, 0, 6'b00_0100));
    vq.push_back(mk(0, 2'b00, 2'b00, 0,   0,  2'b00, 0, 6'b00_0000));
    // round robin with both lanes requesting
    vq.push_back(mk(1, 2'b00, 2'b00, 0,   0,  2'b00, 0, 6'b00_0000));
    vq.push_back(mk(0, 2'b11, 2'b00, 0,   0,  2'b00, 0, 6'b01_0000));
    vq.push_back(mk(0, 2'b11, 2'b01, OK,  0,  2'b00, 0, 6'b01_1000));
    vq.push_back(mk(0, 2'b10, 2'b00, 0,   0,  2'b01, 0, 6'b00_0100));
    vq.push_back(mk(0, 2'b11, 2'b00, 0,   0,  2'b00, 0, 6'b10_0000));
    vq.push_back(mk(0, 2'b11, 2'b01, BAD, 0,  2'b00, 0, 6'b10_0000));
    vq.push_back(mk(0, 2'b11, 2'b10, 0,   OK, 2'b00, 0, 6'b10_1000));
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b10, 0, 6'b00_0100));
    // three wrong PINs -> lockout, unlock, then 2 wrong + correct
    vq.push_back(mk(1, 2'b00, 2'b00, 0,   0,  2'b00, 0, 6'b00_0000));
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b00, 0, 6'b01_0000));
    vq.push_back(mk(0, 2'b01, 2'b01, BAD, 0,  2'b00, 0, 6'b01_0010));
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b00, 0, 6'b01_0000));
    vq.push_back(mk(0, 2'b01, 2'b01, BAD, 0,  2'b00, 0, 6'b01_0010));
    vq.push_back(mk(0, 2'b01, 2'b01, BAD, 0,  2'b00, 0, 6'b00_0011));
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b00, 0, 6'b00_0001));
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b00, 1, 6'b00_0000));
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b00, 0, 6'b01_0000));
    vq.push_back(mk(0, 2'b01, 2'b01, BAD, 0,  2'b00, 0, 6'b01_0010));
    vq.push_back(mk(0, 2'b01, 2'b01, BAD, 0,  2'b00, 0, 6'b01_0010));
    vq.push_back(mk(0, 2'b01, 2'b01, OK,  0,  2'b00, 0, 6'b01_1000));
    // intrusion in OPEN
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b10, 0, 6'b00_0001));
    vq.push_back(mk(0, 2'b00, 2'b00, 0,   0,  2'b00, 1, 6'b00_0000));
    // tailgate in OPEN
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b00, 0, 6'b01_0000));
    vq.push_back(mk(0, 2'b01, 2'b01, OK,  0,  2'b00, 0, 6'b01_1000));
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b01, 0, 6'b00_0001));
    vq.push_back(mk(0, 2'b00, 2'b00, 0,   0,  2'b00, 1, 6'b00_0000));
    // passage sensor while gate closed in PIN
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b00, 0, 6'b01_0000));
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b01, 0, 6'b00_0001));
    vq.push_back(mk(0, 2'b00, 2'b00, 0,   0,  2'b00, 1, 6'b00_0000));
    // reset mid-OPEN: no CP
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b00, 0, 6'b01_0000));
    vq.push_back(mk(0, 2'b01, 2'b01, OK,  0,  2'b00, 0, 6'b01_1000));
    vq.push_back(mk(1, 2'b01, 2'b00, 0,   0,  2'b01, 0, 6'b00_0000));
    vq.push_back(mk(0, 2'b00, 2'b00, 0,   0,  2'b00, 0, 6'b00_0000));
    // strobes on the non-granted lane are ignored
    vq.push_back(mk(0, 2'b01, 2'b00, 0,   0,  2'b00, 0, 6'b01_0000));
    vq.push_back(mk(0, 2'b01, 2'b10, 0,   BAD, 2'b00, 0, 6'b01_0000));
    vq.push_back(mk(0, 2'b01, 2'b10, 0,   OK, 2'b00, 0, 6'b01_0000));
    vq.push_back(mk(0, 2'b00, 2'b00, 0,   0,  2'b00, 0, 6'b00_0000));

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].lv, vq[i].pv, vq[i].c0, vq[i].c1, vq[i].cv, vq[i].br);
      chk($sformatf("vec%0d", i), {GNT, AC, CP, AI, AB}, vq[i].exp);
    end

    // PIN timeout, then round robin hands lane 1 the gate, then OPEN timeout
    step(1, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    step(0, 2'b11, 2'b00, 0, 0, 2'b00, 0);
    chk("to_grant0", {GNT, AC, CP, AI, AB}, 6'b01_0000);
    for (int k = 1; k <= TO; k++) begin
      step(0, 2'b11, 2'b00, 0, 0, 2'b00, 0);
      chk($sformatf("to_pin_wait%0d", k), {GNT, AC, CP, AI, AB}, 6'b01_0000);
    end
    step(0, 2'b11, 2'b00, 0, 0, 2'b00, 0);
    chk("to_pin_expire", {GNT, AC, CP, AI, AB}, 6'b00_0000);
    step(0, 2'b11, 2'b00, 0, 0, 2'b00, 0);
    chk("to_grant1", {GNT, AC, CP, AI, AB}, 6'b10_0000);
    step(0, 2'b11, 2'b10, 0, OK, 2'b00, 0);
    chk("to_open1", {GNT, AC, CP, AI, AB}, 6'b10_1000);
    for (int k = 1; k <= TO; k++) begin
      step(0, 2'b11, 2'b00, 0, 0, 2'b00, 0);
      chk($sformatf("to_open_wait%0d", k), {GNT, AC, CP, AI, AB}, 6'b10_0000);
    end
    step(0, 2'b11, 2'b00, 0, 0, 2'b00, 0);
    chk("to_open_expire", {GNT, AC, CP, AI, AB}, 6'b00_0100);
    step(0, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    chk("to_after", {GNT, AC, CP, AI, AB}, 6'b00_0000);

    // randomized traffic against the model
    step(1, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] lv, pv, cv;
      logic [15:0] a, b;
      logic r, br;
      lv = 2'($urandom_range(0, 3));
      pv = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a  = ($urandom_range(0, 1) == 0) ? OK : 16'($urandom);
      b  = ($urandom_range(0, 1) == 0) ? OK : 16'($urandom);
      cv = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      br = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 299) == 0);
      step(r, lv, pv, a, b, cv, br);
      chk($sformatf("rand%0d", n), {GNT, AC, CP, AI, AB}, model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
